// File: rtl/minimig_mem_pkg.sv
// Shared definitions for the wrap_* SRAM-like bus responder.
// Holds the bus widths, byte-lane indices, FSM state encoding, the latched
// request payload and a lane-masking helper used on the read path.
package minimig_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;

  // Byte-lane indices into a {U,L} enable pair
  localparam int unsigned LANE_L = 0;
  localparam int unsigned LANE_U = 1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request fields captured at acceptance (address is kept separately, its width is a parameter)
  typedef struct packed {
    logic              we;
    logic [1:0]        be;     // {U,L}
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Zero the byte lanes that were not requested
  function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        be);
    lane_mask = {(be[LANE_U] ? d[15:8] : 8'h00), (be[LANE_L] ? d[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/resp_bram.sv
// Single-port synchronous RAM with per-byte write enables.
// Ports: clk; en (access strobe); we[1:0] ({U,L} byte write enables);
//        addr[AW-1:0]; din[15:0]; dout[15:0] (registered, 1-cycle read latency).
// dout only updates on an access, so it holds the last read word.
module resp_bram
  import minimig_mem_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [1:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write plus read-before-write output register
  always_ff @(posedge clk) begin
    if (en) begin
      if (we[LANE_L]) mem[addr][7:0]  <= din[7:0];
      if (we[LANE_U]) mem[addr][15:8] <= din[15:8];
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_bus_responder.sv
// Target end of the 16-bit wrap_* SRAM-like bus, backed by block RAM with
// programmable read/write completion latency.
// Ports: clk; i_rst_n (async active-low); wrap_Addr/CS/L/U/WE/WR (request);
//        wrap_RD (read data, held until next read completes); wrap_ready
//        (one-cycle completion pulse); wrap_busy (transaction in flight);
//        o_dropped (saturating count of request cycles seen while busy).
module sram_bus_responder
  import minimig_mem_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] wrap_Addr,
  input  logic              wrap_CS,
  input  logic              wrap_L,
  input  logic              wrap_U,
  input  logic              wrap_WE,
  input  logic [DATA_W-1:0] wrap_WR,
  output logic [DATA_W-1:0] wrap_RD,
  output logic              wrap_ready,
  output logic              wrap_busy,
  output logic [15:0]       o_dropped
);

  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LATENCY);

  // Latencies below 2 leave no room between RAM access and completion
  if (RD_LATENCY < 2 || WR_LATENCY < 2) begin : g_lat_check
    $error("sram_bus_responder: RD_LATENCY and WR_LATENCY must both be >= 2");
  end

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_c;
  logic              drop_c;
  logic              issue_q;
  logic [AW-1:0]     addr_q;
  req_t              req_q;
  logic [DATA_W-1:0] rd_q;
  logic              ready_q;
  logic              busy_q;
  logic [15:0]       drop_q;
  logic [DATA_W-1:0] ram_dout;
  logic              addr_hi_unused;

  // Upper address bits alias onto the RAM and are deliberately ignored
  assign addr_hi_unused = ^wrap_Addr[ADDR_W-1:AW];

  // Next-state, latency counter and drop detection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    drop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wrap_CS) begin
          accept_c = 1'b1;
          state_d  = ST_WAIT;
          cnt_d    = wrap_WE ? WR_LAT_C : RD_LAT_C;
        end
      end
      ST_WAIT: begin
        drop_c = wrap_CS;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        drop_c  = wrap_CS;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latches and registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      addr_q  <= '0;
      req_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      issue_q <= accept_c;
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_DONE);
      if (accept_c) begin
        addr_q      <= wrap_Addr[AW-1:0];
        req_q.we    <= wrap_WE;
        req_q.be    <= {wrap_U, wrap_L};
        req_q.wdata <= wrap_WR;
      end
      // RAM word has been valid since accept+1; capture it as DONE is entered
      if (state_q == ST_WAIT && state_d == ST_DONE && !req_q.we) begin
        rd_q <= lane_mask(ram_dout, req_q.be);
      end
      if (drop_c && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // RAM access is a single cycle right after acceptance; issue_q is reset, so an
  // aborted transaction never commits
  resp_bram #(
    .AW (AW)
  ) u_bram (
    .clk  (clk),
    .en   (issue_q),
    .we   (req_q.we ? req_q.be : 2'b00),
    .addr (addr_q),
    .din  (req_q.wdata),
    .dout (ram_dout)
  );

  assign wrap_RD    = rd_q;
  assign wrap_ready = ready_q;
  assign wrap_busy  = busy_q;
  assign o_dropped  = drop_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Scoreboard bench for sram_bus_responder: the driver queues expected
// completions and output probes; a negedge monitor checks them.
module tb_sram_bus_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 3;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] wrap_Addr = '0;
  logic        wrap_CS = 1'b0;
  logic        wrap_L = 1'b0;
  logic        wrap_U = 1'b0;
  logic        wrap_WE = 1'b0;
  logic [15:0] wrap_WR = '0;
  logic [15:0] wrap_RD;
  logic        wrap_ready;
  logic        wrap_busy;
  logic [15:0] o_dropped;

  always #5 clk = ~clk;

  sram_bus_responder #(
    .AW         (10),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .wrap_Addr  (wrap_Addr),
    .wrap_CS    (wrap_CS),
    .wrap_L     (wrap_L),
    .wrap_U     (wrap_U),
    .wrap_WE    (wrap_WE),
    .wrap_WR    (wrap_WR),
    .wrap_RD    (wrap_RD),
    .wrap_ready (wrap_ready),
    .wrap_busy  (wrap_busy),
    .o_dropped  (o_dropped)
  );

  typedef struct {
    int          exp_cyc;
    bit          is_rd;
    logic [15:0] data;
  } txn_t;

  // kind: 0 wrap_RD, 1 wrap_ready, 2 wrap_busy, 3 o_dropped
  typedef struct {
    int          kind;
    logic [15:0] exp;
  } probe_t;

  txn_t   sb_q[$];
  probe_t probe_q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  bit     done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sample(input int kind);
    case (kind)
      0:       sample = wrap_RD;
      1:       sample = {15'd0, wrap_ready};
      2:       sample = {15'd0, wrap_busy};
      default: sample = o_dropped;
    endcase
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      0:       kind_name = "probe wrap_RD";
      1:       kind_name = "probe wrap_ready";
      2:       kind_name = "probe wrap_busy";
      default: kind_name = "probe o_dropped";
    endcase
  endfunction

  always @(negedge clk) begin
    txn_t   t;
    probe_t p;
    if (wrap_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected ready", 32'd1, 32'd0);
      end else begin
        t = sb_q.pop_front();
        check("ready latency cycle", cyc, t.exp_cyc);
        check("busy during ready", {31'd0, wrap_busy}, 32'd1);
        if (t.is_rd) check("read data", {16'd0, wrap_RD}, {16'd0, t.data});
      end
    end else if (sb_q.size() != 0 && cyc > sb_q[0].exp_cyc) begin
      t = sb_q.pop_front();
      check("ready overdue", cyc, t.exp_cyc);
    end
    while (probe_q.size() != 0) begin
      p = probe_q.pop_front();
      check(kind_name(p.kind), {16'd0, sample(p.kind)}, {16'd0, p.exp});
    end
    if (done) begin
      check("scoreboard drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  // ---------------- driver ----------------
  // Caller must not be at a negedge when pushing, so the next negedge sees it
  task automatic probe(input int kind, input logic [15:0] exp);
    probe_q.push_back('{kind: kind, exp: exp});
  endtask

  // One request; CS held for extra_cs edges after acceptance to provoke drops
  task automatic xfer(input logic we, input logic [31:0] a, input logic l, input logic u,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input int extra_cs);
    @(negedge clk);
    wrap_CS = 1'b1; wrap_WE = we; wrap_Addr = a; wrap_L = l; wrap_U = u; wrap_WR = wd;
    @(posedge clk); #1;
    sb_q.push_back('{exp_cyc: cyc + (we ? WR_LAT : RD_LAT), is_rd: !we, data: exp_rd});
    repeat (extra_cs) @(posedge clk);
    if (extra_cs > 0) #1;
    wrap_CS = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wrap_ready) break;
    end
  endtask

  initial begin
    // reset state
    #1;
    probe(0, 16'h0000); probe(1, 16'h0000); probe(2, 16'h0000); probe(3, 16'h0000);
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;

    // basic write/read with latency and busy-drop checks
    xfer(1'b1, 32'd5, 1'b1, 1'b1, 16'h1234, 16'h0000, 0);
    #1 probe(2, 16'h0000);
    xfer(1'b0, 32'd5, 1'b1, 1'b1, 16'h0000, 16'h1234, 0);
    #1 probe(2, 16'h0000);

    // byte lanes
    xfer(1'b1, 32'd7, 1'b1, 1'b1, 16'hAAAA, 16'h0000, 0);
    xfer(1'b1, 32'd7, 1'b0, 1'b1, 16'h55FF, 16'h0000, 0);
    xfer(1'b0, 32'd7, 1'b1, 1'b1, 16'h0000, 16'h55AA, 0);
    xfer(1'b0, 32'd7, 1'b1, 1'b0, 16'h0000, 16'h00AA, 0);
    xfer(1'b0, 32'd7, 1'b0, 1'b1, 16'h0000, 16'h5500, 0);

    // address aliasing; wrap_RD held across writes
    xfer(1'b1, 32'h0000_0400, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 0);
    #1 probe(0, 16'h5500);
    xfer(1'b0, 32'd0, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0);

    // no-lane write still completes and leaves RAM alone
    xfer(1'b1, 32'd0, 1'b0, 1'b0, 16'h1111, 16'h0000, 0);
    xfer(1'b0, 32'd0, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 0);

    // CS held across 3 busy edges after acceptance
    #1 probe(3, 16'h0000);
    xfer(1'b1, 32'd20, 1'b1, 1'b1, 16'hC0DE, 16'h0000, 3);
    #1 probe(3, 16'd3);
    xfer(1'b0, 32'd20, 1'b1, 1'b1, 16'h0000, 16'hC0DE, 0);

    // saturation of the drop counter
    @(negedge clk);
    force dut.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_q;
    xfer(1'b1, 32'd21, 1'b1, 1'b1, 16'h0001, 16'h0000, 2);
    #1 probe(3, 16'hFFFF);

    // reset before the write commit
    xfer(1'b1, 32'd9, 1'b1, 1'b1, 16'h5A5A, 16'h0000, 0);
    xfer(1'b0, 32'd9, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 0);
    @(negedge clk);
    wrap_CS = 1'b1; wrap_WE = 1'b1; wrap_Addr = 32'd9; wrap_L = 1'b1; wrap_U = 1'b1;
    wrap_WR = 16'h0F0F;
    @(posedge clk); #1;
    i_rst_n = 1'b0;
    wrap_CS = 1'b0;
    probe(0, 16'h0000); probe(1, 16'h0000); probe(2, 16'h0000); probe(3, 16'h0000);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    xfer(1'b0, 32'd9, 1'b1, 1'b1, 16'h0000, 16'h5A5A, 0);
    #1 probe(3, 16'h0000);

    // initiator sweep: data = address
    for (int i = 0; i < 1024; i++) begin
      xfer(1'b1, 32'(i), 1'b1, 1'b1, 16'(i), 16'h0000, 0);
      xfer(1'b0, 32'(i), 1'b1, 1'b1, 16'h0000, 16'(i), 0);
    end
    #1 probe(3, 16'h0000);

    repeat (3) @(negedge clk);
    #1 done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
